// File: rtl/stream_denormalizer.sv
// Re-emits a dense byte-packed stream as sparse beats sized by a command stream.
// Ports:
//   aclk, areset                  clock, asynchronous active-high reset
//   s_data_*                      packed input stream (tkeep all ones except on tlast)
//   s_len_*                       per-beat byte count commands (1..BYTES), tlast closes a packet
//   m_data_*                      output beats, valid bytes low-aligned, tkeep = (1<<n)-1
//   o_err                         sticky length-mismatch / illegal-command flag
module stream_denormalizer #(
   parameter int unsigned WIDTH = 512,
   parameter int unsigned LW    = $clog2(WIDTH / 8) + 1
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [WIDTH-1:0]     s_data_tdata,
   input  logic [WIDTH/8-1:0]   s_data_tkeep,
   input  logic                 s_data_tlast,
   input  logic                 s_data_tvalid,
   output logic                 s_data_tready,
   input  logic [LW-1:0]        s_len_tdata,
   input  logic                 s_len_tlast,
   input  logic                 s_len_tvalid,
   output logic                 s_len_tready,
   output logic [WIDTH-1:0]     m_data_tdata,
   output logic [WIDTH/8-1:0]   m_data_tkeep,
   output logic                 m_data_tlast,
   output logic                 m_data_tvalid,
   input  logic                 m_data_tready,
   output logic                 o_err
);
   localparam int unsigned BYTES = WIDTH / 8;
   localparam int unsigned CW    = LW + 1;
   localparam int unsigned SW    = 2 * WIDTH;

   logic [SW-1:0]    store_q, store_d;
   logic [CW-1:0]    level_q, level_d;
   logic             pkt_end_q, pkt_end_d;
   logic             discard_q, discard_d;
   logic             err_q, err_d;
   logic             m_valid_q, m_valid_d;
   logic             m_last_q, m_last_d;
   logic [BYTES-1:0] m_keep_q, m_keep_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;

   logic [WIDTH-1:0] keep_bits;
   logic [CW-1:0]    keep_cnt, n_ext, take, lvl_after;
   logic             len_ok, out_free, cmd_ready, fire, fire_ok;
   logic             short_cmd, excess, close, early_last;
   logic             data_ready, accept, drop_in;
   logic [SW-1:0]    shifted, ins_data, ins_mask;

   // Command/input decode, buffer update and output beat formation
   always_comb begin
      keep_bits = '0;
      for (int unsigned i = 0; i < BYTES; i++) keep_bits[i*8 +: 8] = {8{s_data_tkeep[i]}};
      keep_cnt   = CW'($countones(s_data_tkeep));

      n_ext      = CW'(s_len_tdata);
      len_ok     = (n_ext != '0) && (n_ext <= CW'(BYTES));
      out_free   = !m_valid_q || m_data_tready;
      cmd_ready  = out_free && ((level_q >= n_ext) || pkt_end_q);
      fire       = s_len_tvalid && cmd_ready;
      fire_ok    = fire && len_ok;
      take       = fire_ok ? ((level_q < n_ext) ? level_q : n_ext) : '0;
      short_cmd  = fire_ok && pkt_end_q && (level_q < n_ext);
      excess     = fire_ok && s_len_tlast && pkt_end_q && (level_q > n_ext);
      close      = fire_ok && pkt_end_q && (s_len_tlast || short_cmd);
      // Command packet closed while its input packet is still arriving
      early_last = fire_ok && s_len_tlast && !pkt_end_q;

      data_ready = !pkt_end_q && (level_q <= CW'(BYTES));
      accept     = s_data_tvalid && data_ready;
      drop_in    = discard_q || early_last;

      shifted    = store_q >> {take, 3'b000};
      lvl_after  = (close || early_last) ? '0 : (level_q - take);
      ins_data   = SW'(s_data_tdata) << {lvl_after, 3'b000};
      ins_mask   = SW'(keep_bits) << {lvl_after, 3'b000};

      store_d    = shifted;
      level_d    = lvl_after;
      pkt_end_d  = pkt_end_q && !close;
      discard_d  = discard_q || early_last;
      err_d      = err_q || (fire && !len_ok) || short_cmd || excess;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      m_keep_d   = m_keep_q;
      m_data_d   = m_data_q;

      if (accept) begin
         if (drop_in) begin
            if (s_data_tlast) begin
               discard_d = 1'b0;
               err_d     = 1'b1;
            end
         end else begin
            store_d = (shifted & ~ins_mask) | (ins_data & ins_mask);
            level_d = lvl_after + keep_cnt;
            if (s_data_tlast) pkt_end_d = 1'b1;
         end
      end

      if (out_free) begin
         m_valid_d = (take != '0);
         if (take != '0) begin
            m_data_d = store_q[WIDTH-1:0];
            m_keep_d = ~({BYTES{1'b1}} << take);
            m_last_d = s_len_tlast || short_cmd;
         end
      end
   end

   // State registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         store_q   <= '0;
         level_q   <= '0;
         pkt_end_q <= 1'b0;
         discard_q <= 1'b0;
         err_q     <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_keep_q  <= '0;
         m_data_q  <= '0;
      end else begin
         store_q   <= store_d;
         level_q   <= level_d;
         pkt_end_q <= pkt_end_d;
         discard_q <= discard_d;
         err_q     <= err_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_keep_q  <= m_keep_d;
         m_data_q  <= m_data_d;
      end
   end

   assign s_data_tready = data_ready;
   assign s_len_tready  = cmd_ready;
   assign m_data_tdata  = m_data_q;
   assign m_data_tkeep  = m_keep_q;
   assign m_data_tlast  = m_last_q;
   assign m_data_tvalid = m_valid_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_stream_denormalizer.sv
// Self-checking bench for stream_denormalizer: byte-queue reference model,
// randomized packets and commands, plus directed scenarios.
module tb_stream_denormalizer;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned BYTES = WIDTH / 8;
   localparam int unsigned LW    = $clog2(BYTES) + 1;
   localparam int          TO    = 200;

   logic             aclk = 1'b0;
   logic             areset;
   logic [WIDTH-1:0] s_data_tdata;
   logic [BYTES-1:0] s_data_tkeep;
   logic             s_data_tlast, s_data_tvalid, s_data_tready;
   logic [LW-1:0]    s_len_tdata;
   logic             s_len_tlast, s_len_tvalid, s_len_tready;
   logic [WIDTH-1:0] m_data_tdata;
   logic [BYTES-1:0] m_data_tkeep;
   logic             m_data_tlast, m_data_tvalid, m_data_tready;
   logic             o_err;

   stream_denormalizer #(.WIDTH(WIDTH)) dut (
      .aclk(aclk), .areset(areset),
      .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep), .s_data_tlast(s_data_tlast),
      .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
      .s_len_tdata(s_len_tdata), .s_len_tlast(s_len_tlast),
      .s_len_tvalid(s_len_tvalid), .s_len_tready(s_len_tready),
      .m_data_tdata(m_data_tdata), .m_data_tkeep(m_data_tkeep), .m_data_tlast(m_data_tlast),
      .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
      .o_err(o_err)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: bytes held, packet flags, expected output beats
   typedef struct {
      logic [WIDTH-1:0] data;
      logic [BYTES-1:0] keep;
      logic             last;
   } beat_t;

   logic [7:0] mq[$];
   bit         m_pkt_end, m_discard, m_err;
   beat_t      exp_q[$];
   int         out_cycles[$];
   int         cyc = 0;

   logic [7:0] din_q[$];
   int         cmd_n[$];
   bit         cmd_l[$];
   bit         gaps_en = 1'b0;
   int         rdy_mode = 0;

   function automatic logic [WIDTH-1:0] keep_mask(input logic [BYTES-1:0] k);
      logic [WIDTH-1:0] m = '0;
      for (int i = 0; i < BYTES; i++) if (k[i]) m[i*8 +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic model_cmd(input int n, input bit last);
      beat_t b;
      int    avail, take;
      if (n == 0 || n > BYTES) begin
         m_err = 1'b1;
         return;
      end
      avail = mq.size();
      take  = (avail < n) ? avail : n;
      if (take > 0) begin
         b.data = '0;
         for (int i = 0; i < take; i++) b.data[i*8 +: 8] = mq[i];
         b.keep = BYTES'((1 << take) - 1);
         b.last = last || (m_pkt_end && avail < n);
         exp_q.push_back(b);
      end
      for (int i = 0; i < take; i++) void'(mq.pop_front());
      if (m_pkt_end && avail < n) begin
         m_err = 1'b1; mq.delete(); m_pkt_end = 1'b0;
      end else if (last && m_pkt_end) begin
         if (mq.size() != 0) m_err = 1'b1;
         mq.delete(); m_pkt_end = 1'b0;
      end else if (last) begin
         mq.delete(); m_discard = 1'b1;
      end
   endtask

   task automatic model_in(input logic [WIDTH-1:0] d, input logic [BYTES-1:0] k, input bit last);
      if (m_discard) begin
         if (last) begin m_discard = 1'b0; m_err = 1'b1; end
      end else begin
         for (int i = 0; i < BYTES; i++) if (k[i]) mq.push_back(d[i*8 +: 8]);
         if (last) m_pkt_end = 1'b1;
      end
   endtask

   // Monitor: sampled mid-cycle, applies the handshakes of the coming edge
   bit               prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic [BYTES+1:0] prev_ctl;
   always @(negedge aclk) begin
      beat_t e;
      bit    of;
      cyc++;
      if (areset) begin
         mq.delete(); exp_q.delete();
         m_pkt_end = 1'b0; m_discard = 1'b0; m_err = 1'b0; prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_data", m_data_tdata, prev_data);
            check("hold_ctl", {m_data_tvalid, m_data_tlast, m_data_tkeep}, prev_ctl);
         end
         prev_stall = m_data_tvalid && !m_data_tready;
         prev_data  = m_data_tdata;
         prev_ctl   = {m_data_tvalid, m_data_tlast, m_data_tkeep};
         if (m_data_tvalid && m_data_tready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("out_keep", m_data_tkeep, e.keep);
               check("out_data", m_data_tdata & keep_mask(e.keep), e.data);
               check("out_last", m_data_tlast, e.last);
               out_cycles.push_back(cyc);
            end
         end
         check("s_data_tready", s_data_tready, !m_pkt_end && (mq.size() <= BYTES));
         if (s_len_tvalid) begin
            of = !m_data_tvalid || m_data_tready;
            check("s_len_tready", s_len_tready, of && ((mq.size() >= int'(s_len_tdata)) || m_pkt_end));
         end
         if (s_len_tvalid && s_len_tready) model_cmd(int'(s_len_tdata), s_len_tlast);
         if (s_data_tvalid && s_data_tready) model_in(s_data_tdata, s_data_tkeep, s_data_tlast);
      end
   end

   // Output ready generator: 0 always ready, 1 random, otherwise left to the test
   initial begin
      m_data_tready = 1'b1;
      forever begin
         @(posedge aclk); #1;
         if (rdy_mode == 0) m_data_tready = 1'b1;
         else if (rdy_mode == 1) m_data_tready = ($urandom_range(0, 9) < 7);
      end
   end

   task automatic tick();
      @(posedge aclk); #1;
   endtask

   task automatic drive_data();
      logic [WIDTH-1:0] d;
      logic [BYTES-1:0] k;
      int nb, waitc;
      bit hs;
      while (din_q.size() > 0) begin
         if (gaps_en) repeat ($urandom_range(0, 2)) tick();
         nb = (din_q.size() < BYTES) ? din_q.size() : BYTES;
         d = '0; k = '0;
         for (int i = 0; i < nb; i++) begin d[i*8 +: 8] = din_q.pop_front(); k[i] = 1'b1; end
         s_data_tdata = d; s_data_tkeep = k; s_data_tlast = (din_q.size() == 0);
         s_data_tvalid = 1'b1;
         hs = 1'b0; waitc = 0;
         while (!hs) begin
            @(negedge aclk); hs = s_data_tready;
            tick();
            waitc++;
            if (!hs && waitc >= TO) begin check("data_timeout", 0, 1); din_q.delete(); hs = 1'b1; end
         end
         s_data_tvalid = 1'b0;
      end
   endtask

   task automatic drive_cmds();
      int waitc;
      bit hs;
      while (cmd_n.size() > 0) begin
         if (gaps_en) repeat ($urandom_range(0, 2)) tick();
         s_len_tdata = LW'(cmd_n.pop_front());
         s_len_tlast = cmd_l.pop_front();
         s_len_tvalid = 1'b1;
         hs = 1'b0; waitc = 0;
         while (!hs) begin
            @(negedge aclk); hs = s_len_tready;
            tick();
            waitc++;
            if (!hs && waitc >= TO) begin
               check("cmd_timeout", 0, 1); cmd_n.delete(); cmd_l.delete(); hs = 1'b1;
            end
         end
         s_len_tvalid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_data_tvalid) && n < TO) begin tick(); n++; end
      check("drain", (exp_q.size() == 0) && !m_data_tvalid, 1);
   endtask

   task automatic run_pkt(input string tag);
      fork
         drive_data();
         drive_cmds();
      join
      wait_drain();
      check({tag, "_o_err"}, o_err, m_err);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      repeat (2) tick();
      areset = 1'b0;
      tick();
      check("rst_valid", m_data_tvalid, 0);
      check("rst_err", o_err, 0);
   endtask

   task automatic push_bytes(input int first, input int count);
      for (int i = 0; i < count; i++) din_q.push_back(8'(first + i));
   endtask

   task automatic push_cmd(input int n, input bit last);
      cmd_n.push_back(n); cmd_l.push_back(last);
   endtask

   task automatic gen_random();
      int len, kind, total, rem, n, li;
      len = $urandom_range(1, 3 * BYTES);
      for (int i = 0; i < len; i++) din_q.push_back(8'($urandom_range(0, 255)));
      kind  = $urandom_range(0, 9);
      total = len;
      if (kind == 7 && len >= 2) total = len - $urandom_range(1, len - 1);
      if (kind == 8) push_cmd(0, 1'b0);
      rem = total;
      while (rem > 0) begin
         n = $urandom_range(1, (rem < BYTES) ? rem : BYTES);
         rem -= n;
         push_cmd(n, rem == 0);
      end
      li = cmd_n.size() - 1;
      if (kind == 5 && cmd_n[li] < BYTES) cmd_n[li] = cmd_n[li] + $urandom_range(1, BYTES - cmd_n[li]);
      if (kind == 6) begin cmd_l[li] = 1'b0; push_cmd($urandom_range(1, BYTES), 1'b1); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_wait;
      areset = 1'b1;
      s_data_tdata = '0; s_data_tkeep = '0; s_data_tlast = 1'b0; s_data_tvalid = 1'b0;
      s_len_tdata = '0; s_len_tlast = 1'b0; s_len_tvalid = 1'b0;
      repeat (3) tick();
      check("reset_valid", m_data_tvalid, 0);
      check("reset_err", o_err, 0);
      check("reset_keep", m_data_tkeep, 0);
      check("reset_last", m_data_tlast, 0);
      areset = 1'b0;
      tick();

      // Mixed sizes across two full beats
      push_bytes(0, 16);
      push_cmd(3, 0); push_cmd(5, 0); push_cmd(7, 0); push_cmd(1, 1);
      run_pkt("mixed");

      // Full-width passthrough at one beat per cycle
      out_cycles.delete();
      push_bytes(8'h20, 32);
      for (int i = 0; i < 4; i++) push_cmd(8, i == 3);
      run_pkt("pass");
      check("pass_beats", out_cycles.size(), 4);
      if (out_cycles.size() == 4) check("pass_rate", out_cycles[3] - out_cycles[0], 3);

      // Output stall mid-packet
      rdy_mode = 3;
      push_bytes(8'h40, 24);
      for (int i = 0; i < 4; i++) push_cmd(6, i == 3);
      fork
         drive_data();
         drive_cmds();
         begin
            hs_wait = 0;
            while (!m_data_tvalid && hs_wait < TO) begin tick(); hs_wait++; end
            m_data_tready = 1'b0;
            repeat (5) tick();
            m_data_tready = 1'b1;
         end
      join
      rdy_mode = 0;
      wait_drain();
      check("stall_o_err", o_err, m_err);

      // Short data: 5 bytes against an 8-byte command
      push_bytes(8'h60, 5);
      push_cmd(8, 1);
      run_pkt("short");

      // Excess data: 8 bytes against a 3-byte closing command, then a clean packet
      push_bytes(8'h70, 8);
      push_cmd(3, 1);
      run_pkt("excess");
      push_bytes(8'h80, 10);
      push_cmd(4, 0); push_cmd(6, 1);
      run_pkt("after_excess");

      // Asynchronous reset mid-packet
      rdy_mode = 3; m_data_tready = 1'b0;
      push_cmd(0, 0);
      drive_cmds();
      push_bytes(8'h90, 9);
      din_q.delete();
      push_bytes(8'h90, 8);
      s_data_tdata = {8'h97, 8'h96, 8'h95, 8'h94, 8'h93, 8'h92, 8'h91, 8'h90};
      s_data_tkeep = '1; s_data_tlast = 1'b0; s_data_tvalid = 1'b1;
      hs_wait = 0;
      while (!s_data_tready && hs_wait < TO) begin tick(); hs_wait++; end
      tick();
      s_data_tvalid = 1'b0;
      din_q.delete();
      push_cmd(2, 0);
      drive_cmds();
      repeat (2) tick();
      check("pre_rst_valid", m_data_tvalid, 1);
      check("pre_rst_err", o_err, 1);
      #2 areset = 1'b1;
      #1;
      check("async_rst_valid", m_data_tvalid, 0);
      check("async_rst_err", o_err, 0);
      repeat (2) tick();
      areset = 1'b0;
      rdy_mode = 0;
      tick();
      push_bytes(8'hA0, 12);
      push_cmd(5, 0); push_cmd(7, 1);
      run_pkt("post_rst");

      // Randomized packets with gaps and back-pressure
      gaps_en = 1'b1; rdy_mode = 1;
      for (int p = 0; p < 60; p++) begin
         gen_random();
         run_pkt("rand");
         if (m_err) begin
            rdy_mode = 0;
            do_reset();
            rdy_mode = 1;
         end
      end
      rdy_mode = 0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
